// File: rtl/cella_pkg.sv
// Shared definitions for the CIM array command interface: op codes,
// address field layout and the issuer state encoding.
package cella_pkg;

    localparam logic [1:0] OP_MAC   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_QUERY = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // Array address layout: {bank, row, col}
    localparam int BANK_W   = 4;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 3;
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_LSB + COL_W;
    localparam int BANK_LSB = ROW_LSB + ROW_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_MAC,
        ST_MAC_WAIT,
        ST_QUERY,
        ST_DONE
    } issuer_state_e;

endpackage

// File: rtl/array_cmd_issuer.sv
// Initiator side of the CIM array command interface. Accepts one host
// command at a time and expands it into the per-cycle op stream seen by
// the array decoder. Outputs are registered together with the state
// transition that produces them, so an op is visible the cycle after the
// edge that caused it.
module array_cmd_issuer
    import cella_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 8,
    parameter int MAC_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data_bank,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic [1:0]        op_code,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_bank,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done
);

    issuer_state_e            state_q, state_d;
    logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]         rem_q, rem_d;
    logic                     last_q, last_d;     // final write word already issued
    logic [3:0]               wait_q, wait_d;
    logic [COL_W-1:0]         col_q, col_d;       // column currently on the outputs
    logic [ADDR_W-COL_W-1:0]  base_q, base_d;     // bank/row of a query sweep
    logic [3:0]               key_q, key_d;
    logic [1:0]               op_q, op_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        bank_q, bank_d;
    logic [DATA_W-1:0]        din_q, din_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    assign req_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE) && !last_q;
    assign op_code     = op_q;
    assign addr        = addr_q;
    assign data_bank   = bank_q;
    assign data_in     = din_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // State, counters and registered outputs; reset aborts any command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            wait_q     <= '0;
            col_q      <= '0;
            base_q     <= '0;
            key_q      <= '0;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            bank_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            col_q      <= col_d;
            base_q     <= base_d;
            key_q      <= key_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state, counter updates and the op to present next cycle.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        last_d     = last_q;
        wait_d     = wait_q;
        col_d      = col_q;
        base_d     = base_q;
        key_d      = key_q;
        op_d       = OP_NOP;
        addr_d     = '0;
        bank_d     = '0;
        din_d      = '0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    unique case (req_op)
                        OP_MAC: begin
                            op_d    = OP_MAC;
                            bank_d  = req_data_bank;
                            din_d   = req_data_in;
                            state_d = ST_MAC;
                        end
                        OP_WRITE: begin
                            cur_addr_d = req_addr;
                            rem_d      = req_len;
                            last_d     = 1'b0;
                            state_d    = ST_WRITE;
                        end
                        OP_QUERY: begin
                            base_d  = req_addr[ADDR_W-1:COL_W];
                            key_d   = req_data_bank[3:0];
                            col_d   = '0;
                            op_d    = OP_QUERY;
                            addr_d  = {req_addr[ADDR_W-1:COL_W], {COL_W{1'b0}}};
                            bank_d  = DATA_W'(req_data_bank[3:0]);
                            state_d = ST_QUERY;
                        end
                        default: begin
                            // Reserved op retires without touching the array.
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MAC: begin
                wait_d  = 4'(MAC_WAIT - 1);
                state_d = ST_MAC_WAIT;
            end
            ST_MAC_WAIT: begin
                if (wait_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WRITE: begin
                if (last_q) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (wdata_valid) begin
                    op_d       = OP_WRITE;
                    addr_d     = cur_addr_q;
                    bank_d     = wdata;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    if (rem_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            ST_QUERY: begin
                if (col_q == {COL_W{1'b1}}) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    col_d  = col_q + COL_W'(1);
                    op_d   = OP_QUERY;
                    addr_d = {base_q, col_q + COL_W'(1)};
                    bank_d = DATA_W'(key_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule
